// File: rtl/core_mem_responder_pkg.sv
// rtl/core_mem_responder_pkg.sv - shared state type, select codes and default sizes for core_mem_responder
package core_mem_pkg;

  typedef enum logic [2:0] {
    LOAD  = 3'd0,
    START = 3'd1,
    RUN   = 3'd2,
    DUMP  = 3'd3,
    DONE  = 3'd4
  } mem_state_t;

  localparam logic SEL_INS = 1'b0;
  localparam logic SEL_DM  = 1'b1;

  localparam int DEF_REG_WIDTH = 12;
  localparam int DEF_INS_DEPTH = 256;
  localparam int DEF_DM_DEPTH  = 256;
  localparam int DEF_DUMP_LEN  = 256;

  // Index width for a power-of-two memory; a single-word memory still gets one bit.
  function automatic int idx_bits(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/core_mem_responder_if.sv
// rtl/core_mem_responder_if.sv - core, host load and dump signals of core_mem_responder
interface core_mem_responder_if
  import core_mem_pkg::*;
#(
  parameter int reg_width = DEF_REG_WIDTH
);

  logic [reg_width-1:0] addr;
  logic [reg_width-1:0] wr_data;
  logic                 mem_write;
  logic                 endop_signal;
  logic [reg_width-1:0] ins_dataout;
  logic [reg_width-1:0] dm_dataout;
  logic                 core_start;
  logic                 core_busy;

  logic                 host_valid;
  logic                 host_ready;
  logic                 host_sel;
  logic [reg_width-1:0] host_data;
  logic                 host_last;
  logic                 host_restart;

  logic                 dump_valid;
  logic                 dump_ready;
  logic [reg_width-1:0] dump_data;
  logic                 dump_last;

  modport slave (
    input  addr, wr_data, mem_write, endop_signal,
    input  host_valid, host_sel, host_data, host_last, host_restart,
    input  dump_ready,
    output ins_dataout, dm_dataout, core_start, core_busy,
    output host_ready,
    output dump_valid, dump_data, dump_last
  );

  modport master (
    output addr, wr_data, mem_write, endop_signal,
    output host_valid, host_sel, host_data, host_last, host_restart,
    output dump_ready,
    input  ins_dataout, dm_dataout, core_start, core_busy,
    input  host_ready,
    input  dump_valid, dump_data, dump_last
  );

endinterface

// File: rtl/core_mem_responder_sync_ram.sv
// rtl/core_mem_responder_sync_ram.sv - single-port synchronous RAM with registered read-before-write
module sync_ram
  import core_mem_pkg::*;
#(
  parameter int  width = DEF_REG_WIDTH,
  parameter int  depth = DEF_INS_DEPTH,
  localparam int aw    = idx_bits(depth)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             we,
  input  logic [aw-1:0]    addr,
  input  logic [width-1:0] wdata,
  output logic [width-1:0] rdata
);

  logic [width-1:0] mem [depth];

  // Array has no reset so contents survive a reset of the surrounding logic.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/core_mem_responder.sv
// rtl/core_mem_responder.sv - instruction/data memory responder with host preload, core start and dump stream
module core_mem_responder
  import core_mem_pkg::*;
#(
  parameter int reg_width = DEF_REG_WIDTH,
  parameter int ins_depth = DEF_INS_DEPTH,
  parameter int dm_depth  = DEF_DM_DEPTH,
  parameter int dump_len  = DEF_DUMP_LEN
) (
  input  logic                 clk,
  input  logic                 reset,
  core_mem_responder_if.slave  bus
);

  localparam int ins_aw = idx_bits(ins_depth);
  localparam int dm_aw  = idx_bits(dm_depth);
  localparam logic [dm_aw-1:0] dump_last_idx = dm_aw'(dump_len - 1);

  mem_state_t state;

  logic [ins_aw-1:0]    ins_cnt;
  logic [dm_aw-1:0]     dm_cnt;
  logic [dm_aw-1:0]     dump_cnt;
  logic                 dump_valid_r;

  logic                 host_hs;
  logic                 dump_hs;
  logic                 dump_at_last;
  logic                 dump_rd;
  logic [dm_aw-1:0]     dump_rd_addr;

  logic                 ins_en;
  logic                 ins_we;
  logic [ins_aw-1:0]    ins_addr;
  logic [reg_width-1:0] ins_wdata;
  logic [reg_width-1:0] ins_q;

  logic                 dm_en;
  logic                 dm_we;
  logic [dm_aw-1:0]     dm_addr;
  logic [reg_width-1:0] dm_wdata;
  logic [reg_width-1:0] dm_q;

  logic                 dm_q_dump;
  logic [reg_width-1:0] core_hold;
  logic [reg_width-1:0] dump_hold;

  assign host_hs      = (state == LOAD) && bus.host_valid;
  assign dump_hs      = dump_valid_r && bus.dump_ready;
  assign dump_at_last = (dump_cnt == dump_last_idx);

  // Read the next dump word on the prefetch cycle and on every handshake except the final one.
  assign dump_rd      = (state == DUMP) && (!dump_valid_r || (bus.dump_ready && !dump_at_last));
  assign dump_rd_addr = dump_valid_r ? dump_cnt + dm_aw'(1) : dump_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= LOAD;
      ins_cnt      <= '0;
      dm_cnt       <= '0;
      dump_cnt     <= '0;
      dump_valid_r <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (host_hs) begin
            if (bus.host_sel == SEL_INS) begin
              ins_cnt <= ins_cnt + ins_aw'(1);
            end else begin
              dm_cnt <= dm_cnt + dm_aw'(1);
            end
            if (bus.host_last) begin
              state <= START;
            end
          end
        end
        START: begin
          state <= RUN;
        end
        RUN: begin
          if (bus.endop_signal) begin
            state    <= DUMP;
            dump_cnt <= '0;
          end
        end
        DUMP: begin
          if (!dump_valid_r) begin
            dump_valid_r <= 1'b1;
          end else if (dump_hs) begin
            if (dump_at_last) begin
              dump_valid_r <= 1'b0;
              state        <= DONE;
            end else begin
              dump_cnt <= dump_cnt + dm_aw'(1);
            end
          end
        end
        DONE: begin
          if (bus.host_restart) begin
            state   <= LOAD;
            ins_cnt <= '0;
            dm_cnt  <= '0;
          end
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

  // Memory port mux: host counters while loading, core address while running, dump pointer while dumping.
  always_comb begin
    ins_en    = 1'b0;
    ins_we    = 1'b0;
    ins_addr  = ins_cnt;
    ins_wdata = bus.host_data;
    dm_en     = 1'b0;
    dm_we     = 1'b0;
    dm_addr   = dm_cnt;
    dm_wdata  = bus.host_data;
    case (state)
      LOAD: begin
        ins_we = !reset && host_hs && (bus.host_sel == SEL_INS);
        dm_we  = !reset && host_hs && (bus.host_sel == SEL_DM);
      end
      RUN: begin
        ins_en   = 1'b1;
        ins_addr = bus.addr[ins_aw-1:0];
        dm_en    = 1'b1;
        dm_we    = !reset && bus.mem_write;
        dm_addr  = bus.addr[dm_aw-1:0];
        dm_wdata = bus.wr_data;
      end
      DUMP: begin
        dm_en   = dump_rd;
        dm_addr = dump_rd_addr;
      end
      default: begin
      end
    endcase
  end

  sync_ram #(
    .width (reg_width),
    .depth (ins_depth)
  ) u_ins_ram (
    .clk   (clk),
    .rst   (reset),
    .en    (ins_en),
    .we    (ins_we),
    .addr  (ins_addr),
    .wdata (ins_wdata),
    .rdata (ins_q)
  );

  sync_ram #(
    .width (reg_width),
    .depth (dm_depth)
  ) u_dm_ram (
    .clk   (clk),
    .rst   (reset),
    .en    (dm_en),
    .we    (dm_we),
    .addr  (dm_addr),
    .wdata (dm_wdata),
    .rdata (dm_q)
  );

  // The data RAM read register is shared by core reads and dump reads; whichever use it
  // does not currently own keeps its last value in a hold register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dm_q_dump <= 1'b0;
      core_hold <= '0;
      dump_hold <= '0;
    end else begin
      if (dm_en) begin
        dm_q_dump <= (state == DUMP);
      end
      if (dm_q_dump) begin
        dump_hold <= dm_q;
      end else begin
        core_hold <= dm_q;
      end
    end
  end

  assign bus.ins_dataout = ins_q;
  assign bus.dm_dataout  = dm_q_dump ? core_hold : dm_q;
  assign bus.dump_data   = dm_q_dump ? dm_q : dump_hold;
  assign bus.dump_valid  = dump_valid_r;
  assign bus.dump_last   = dump_valid_r && dump_at_last;
  assign bus.host_ready  = (state == LOAD);
  assign bus.core_start  = (state == START);
  assign bus.core_busy   = (state == RUN);

endmodule
